// File: rtl/ula_sequencial.sv
// Multi-cycle ALU: single-cycle logic/arith/shift ops plus iterative multiply and
// restoring divide, all behind a start/busy/done handshake with registered flags.
module ula_sequencial #(
    parameter int LARGURA = 8
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [LARGURA-1:0] entrada1,
    input  logic [LARGURA-1:0] entrada2,
    input  logic [3:0]         sinal_ula,
    input  logic               inicio,
    output logic               ocupado,
    output logic               pronto,
    output logic [LARGURA-1:0] saida_ula,
    output logic               zero,
    output logic               carry,
    output logic               overflow,
    output logic               div_zero,
    output logic               invalido
);

    localparam int SW = $clog2(LARGURA);
    localparam int CW = SW + 1;
    localparam logic [CW-1:0] ULTIMA = CW'(LARGURA - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_SLT = 4'b0100;
    localparam logic [3:0] OP_XOR = 4'b0101;
    localparam logic [3:0] OP_NOR = 4'b0110;
    localparam logic [3:0] OP_SLL = 4'b0111;
    localparam logic [3:0] OP_SRL = 4'b1000;
    localparam logic [3:0] OP_SRA = 4'b1001;
    localparam logic [3:0] OP_MUL = 4'b1010;
    localparam logic [3:0] OP_DIV = 4'b1011;
    localparam logic [3:0] OP_REM = 4'b1100;

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        MULT   = 2'd1,
        DIVI   = 2'd2
    } estado_t;

    estado_t            estado_q, estado_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [3:0]         op_q, op_d;
    logic [LARGURA-1:0] a_q, a_d;
    logic [LARGURA-1:0] b_q, b_d;
    logic [LARGURA-1:0] acc_q, acc_d;
    logic               pronto_q, pronto_d;
    logic [LARGURA-1:0] saida_q, saida_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               overflow_q, overflow_d;
    logic               div_zero_q, div_zero_d;
    logic               invalido_q, invalido_d;

    // Single-cycle datapath, evaluated directly on the live inputs
    logic [LARGURA:0]   soma_ext;
    logic [LARGURA-1:0] dif;
    logic [SW-1:0]      shamt;
    logic [LARGURA-1:0] alu_res;
    logic               alu_c, alu_v, alu_dz, alu_inv;

    assign soma_ext = {1'b0, entrada1} + {1'b0, entrada2};
    assign dif      = entrada1 - entrada2;
    assign shamt    = entrada2[SW-1:0];

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_dz  = 1'b0;
        alu_inv = 1'b0;
        case (sinal_ula)
            OP_AND: alu_res = entrada1 & entrada2;
            OP_OR:  alu_res = entrada1 | entrada2;
            OP_ADD: begin
                alu_res = soma_ext[LARGURA-1:0];
                alu_c   = soma_ext[LARGURA];
                alu_v   = (entrada1[LARGURA-1] == entrada2[LARGURA-1]) &&
                          (soma_ext[LARGURA-1] != entrada1[LARGURA-1]);
            end
            OP_SUB: begin
                alu_res = dif;
                alu_c   = (entrada1 < entrada2);
                alu_v   = (entrada1[LARGURA-1] != entrada2[LARGURA-1]) &&
                          (dif[LARGURA-1] != entrada1[LARGURA-1]);
            end
            OP_SLT: alu_res = {{(LARGURA-1){1'b0}}, ($signed(entrada1) < $signed(entrada2))};
            OP_XOR: alu_res = entrada1 ^ entrada2;
            OP_NOR: alu_res = ~(entrada1 | entrada2);
            OP_SLL: alu_res = entrada1 << shamt;
            OP_SRL: alu_res = entrada1 >> shamt;
            OP_SRA: alu_res = $unsigned($signed(entrada1) >>> shamt);
            OP_MUL: alu_res = '0;
            // Only reached as a single-cycle op when the divisor is zero
            OP_DIV: begin
                alu_res = '1;
                alu_dz  = 1'b1;
            end
            OP_REM: begin
                alu_res = entrada1;
                alu_dz  = 1'b1;
            end
            default: alu_inv = 1'b1;
        endcase
    end

    // Iteration datapaths
    logic [LARGURA-1:0] mul_soma;
    logic [LARGURA:0]   rem_desl;
    logic [LARGURA:0]   rem_sub;
    logic               q_bit;
    logic [LARGURA-1:0] rem_novo;
    logic [LARGURA-1:0] quoc_novo;

    assign mul_soma  = acc_q + (b_q[0] ? a_q : '0);
    assign rem_desl  = {acc_q, a_q[LARGURA-1]};
    assign rem_sub   = rem_desl - {1'b0, b_q};
    assign q_bit     = ~rem_sub[LARGURA];
    assign rem_novo  = q_bit ? rem_sub[LARGURA-1:0] : rem_desl[LARGURA-1:0];
    assign quoc_novo = {a_q[LARGURA-2:0], q_bit};

    logic               concluir;
    logic [LARGURA-1:0] res_fin;
    logic               c_fin, v_fin, dz_fin, inv_fin;

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        acc_d      = acc_q;
        pronto_d   = 1'b0;
        saida_d    = saida_q;
        zero_d     = zero_q;
        carry_d    = carry_q;
        overflow_d = overflow_q;
        div_zero_d = div_zero_q;
        invalido_d = invalido_q;
        concluir   = 1'b0;
        res_fin    = '0;
        c_fin      = 1'b0;
        v_fin      = 1'b0;
        dz_fin     = 1'b0;
        inv_fin    = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (inicio) begin
                    op_d  = sinal_ula;
                    a_d   = entrada1;
                    b_d   = entrada2;
                    acc_d = '0;
                    cnt_d = '0;
                    if (sinal_ula == OP_MUL) begin
                        estado_d = MULT;
                    end else if ((sinal_ula == OP_DIV || sinal_ula == OP_REM) &&
                                 (entrada2 != '0)) begin
                        estado_d = DIVI;
                    end else begin
                        concluir = 1'b1;
                        res_fin  = alu_res;
                        c_fin    = alu_c;
                        v_fin    = alu_v;
                        dz_fin   = alu_dz;
                        inv_fin  = alu_inv;
                    end
                end
            end
            MULT: begin
                acc_d = mul_soma;
                a_d   = a_q << 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ULTIMA) begin
                    concluir = 1'b1;
                    res_fin  = mul_soma;
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            end
            DIVI: begin
                acc_d = rem_novo;
                a_d   = quoc_novo;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == ULTIMA) begin
                    concluir = 1'b1;
                    res_fin  = (op_q == OP_REM) ? rem_novo : quoc_novo;
                    estado_d = OCIOSO;
                    cnt_d    = '0;
                end
            end
            default: begin
                estado_d = OCIOSO;
                cnt_d    = '0;
            end
        endcase

        if (concluir) begin
            pronto_d   = 1'b1;
            saida_d    = res_fin;
            zero_d     = (res_fin == '0);
            carry_d    = c_fin;
            overflow_d = v_fin;
            div_zero_d = dz_fin;
            invalido_d = inv_fin;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_q   <= OCIOSO;
            cnt_q      <= '0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            pronto_q   <= 1'b0;
            saida_q    <= '0;
            zero_q     <= 1'b0;
            carry_q    <= 1'b0;
            overflow_q <= 1'b0;
            div_zero_q <= 1'b0;
            invalido_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            acc_q      <= acc_d;
            pronto_q   <= pronto_d;
            saida_q    <= saida_d;
            zero_q     <= zero_d;
            carry_q    <= carry_d;
            overflow_q <= overflow_d;
            div_zero_q <= div_zero_d;
            invalido_q <= invalido_d;
        end
    end

    assign ocupado   = (estado_q != OCIOSO);
    assign pronto    = pronto_q;
    assign saida_ula = saida_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = overflow_q;
    assign div_zero  = div_zero_q;
    assign invalido  = invalido_q;

endmodule

// File: tb/tb_ula_sequencial.sv
// Scoreboard bench for ula_sequencial (LARGURA=8): stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every pronto pulse.
module tb_ula_sequencial;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] entrada1 = '0;
    logic [7:0] entrada2 = '0;
    logic [3:0] sinal_ula = '0;
    logic       inicio = 1'b0;
    logic       ocupado, pronto, zero, carry, overflow, div_zero, invalido;
    logic [7:0] saida_ula;

    ula_sequencial #(.LARGURA(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .entrada1  (entrada1),
        .entrada2  (entrada2),
        .sinal_ula (sinal_ula),
        .inicio    (inicio),
        .ocupado   (ocupado),
        .pronto    (pronto),
        .saida_ula (saida_ula),
        .zero      (zero),
        .carry     (carry),
        .overflow  (overflow),
        .div_zero  (div_zero),
        .invalido  (invalido)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [7:0] res;
        bit         z, c, v, dz, inv;
        int         cyc;
        int         busy;
        string      nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Monitor: one line per completed transaction
    always @(negedge clock) begin
        exp_t e;
        if (!reset_n) begin
            busy_cnt = 0;
        end else begin
            if (ocupado) busy_cnt++;
            if (pronto) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pronto: got pronto=1 with result %0d expected no completion", saida_ula);
                end else begin
                    e = sb.pop_front();
                    $display("txn %s: result=%0d z=%0b c=%0b v=%0b dz=%0b inv=%0b cycle=%0d busy=%0d",
                             e.nm, saida_ula, zero, carry, overflow, div_zero, invalido, cyc, busy_cnt);
                    check({e.nm, ".result"},   int'(saida_ula), int'(e.res));
                    check({e.nm, ".zero"},     int'(zero),      int'(e.z));
                    check({e.nm, ".carry"},    int'(carry),     int'(e.c));
                    check({e.nm, ".overflow"}, int'(overflow),  int'(e.v));
                    check({e.nm, ".div_zero"}, int'(div_zero),  int'(e.dz));
                    check({e.nm, ".invalido"}, int'(invalido),  int'(e.inv));
                    check({e.nm, ".latency"},  cyc,             e.cyc);
                    check({e.nm, ".busy"},     busy_cnt,        e.busy);
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic start(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input bit z, input bit c, input bit v,
                         input bit dz, input bit inv, input int lat, input string nm);
        exp_t e;
        @(negedge clock);
        sinal_ula = op;
        entrada1  = a;
        entrada2  = b;
        inicio    = 1'b1;
        e.res = r; e.z = z; e.c = c; e.v = v; e.dz = dz; e.inv = inv;
        e.cyc = cyc + 1 + lat;
        e.busy = lat;
        e.nm = nm;
        sb.push_back(e);
    endtask

    task automatic finish_op(input int lat);
        @(negedge clock);
        inicio = 1'b0;
        repeat (lat) @(negedge clock);
    endtask

    task automatic check_outputs_zero(input string nm);
        check({nm, ".saida"},    int'(saida_ula), 0);
        check({nm, ".zero"},     int'(zero),      0);
        check({nm, ".pronto"},   int'(pronto),    0);
        check({nm, ".ocupado"},  int'(ocupado),   0);
        check({nm, ".carry"},    int'(carry),     0);
        check({nm, ".overflow"}, int'(overflow),  0);
        check({nm, ".div_zero"}, int'(div_zero),  0);
        check({nm, ".invalido"}, int'(invalido),  0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(negedge clock);
        check_outputs_zero("reset");
        reset_n = 1'b1;

        // Back-to-back ADDs: inicio held high across two edges
        start(4'b0010, 8'd200, 8'd100, 8'd44,  0, 1, 0, 0, 0, 0, "add_200_100");
        start(4'b0010, 8'd100, 8'd100, 8'd200, 0, 0, 1, 0, 0, 0, "add_100_100");
        finish_op(0);

        start(4'b0011, 8'd4,   8'd4,   8'd0,   1, 0, 0, 0, 0, 0, "sub_4_4");     finish_op(0);
        start(4'b0011, 8'd4,   8'd23,  8'd237, 0, 1, 0, 0, 0, 0, "sub_4_23");    finish_op(0);
        start(4'b0100, 8'hFB,  8'h04,  8'd1,   0, 0, 0, 0, 0, 0, "slt_neg5_4");  finish_op(0);
        start(4'b0100, 8'd5,   8'd4,   8'd0,   1, 0, 0, 0, 0, 0, "slt_5_4");     finish_op(0);
        start(4'b0000, 8'hF0,  8'h3C,  8'h30,  0, 0, 0, 0, 0, 0, "and");         finish_op(0);
        start(4'b0001, 8'hF0,  8'h3C,  8'hFC,  0, 0, 0, 0, 0, 0, "or");          finish_op(0);
        start(4'b0101, 8'hF0,  8'h3C,  8'hCC,  0, 0, 0, 0, 0, 0, "xor");         finish_op(0);
        start(4'b0110, 8'hF0,  8'h3C,  8'h03,  0, 0, 0, 0, 0, 0, "nor");         finish_op(0);
        start(4'b1001, 8'h80,  8'd3,   8'hF0,  0, 0, 0, 0, 0, 0, "sra_80_3");    finish_op(0);
        start(4'b1000, 8'h80,  8'h0B,  8'h10,  0, 0, 0, 0, 0, 0, "srl_80_0b");   finish_op(0);
        start(4'b0111, 8'h01,  8'd7,   8'h80,  0, 0, 0, 0, 0, 0, "sll_01_7");    finish_op(0);
        start(4'b1111, 8'd9,   8'd9,   8'd0,   1, 0, 0, 0, 1, 0, "invalid_f");   finish_op(0);

        // MUL 13x11 with an ignored start pulse and operand changes in flight
        start(4'b1010, 8'd13, 8'd11, 8'd143, 0, 0, 0, 0, 0, 8, "mul_13_11");
        @(negedge clock); inicio = 1'b0;
        @(negedge clock);
        @(negedge clock);
        sinal_ula = 4'b0010; entrada1 = 8'd99; entrada2 = 8'd7; inicio = 1'b1;
        @(negedge clock);
        inicio = 1'b0; entrada1 = 8'd200; entrada2 = 8'd3;
        repeat (5) @(negedge clock);

        start(4'b1010, 8'd20, 8'd20, 8'd144, 0, 0, 0, 0, 0, 8, "mul_20_20");  finish_op(8);
        start(4'b1011, 8'd23, 8'd4,  8'd5,   0, 0, 0, 0, 0, 8, "div_23_4");   finish_op(8);
        start(4'b1100, 8'd23, 8'd4,  8'd3,   0, 0, 0, 0, 0, 8, "rem_23_4");   finish_op(8);
        start(4'b1011, 8'd9,  8'd0,  8'd255, 0, 0, 0, 1, 0, 0, "div_9_0");    finish_op(0);
        start(4'b1100, 8'd9,  8'd0,  8'd9,   0, 0, 0, 1, 0, 0, "rem_9_0");    finish_op(0);

        // Abort a MUL during its fourth busy cycle; no completion may follow
        @(negedge clock);
        sinal_ula = 4'b1010; entrada1 = 8'd13; entrada2 = 8'd11; inicio = 1'b1;
        @(negedge clock); inicio = 1'b0;
        repeat (3) @(negedge clock);
        check("abort.busy_before", int'(ocupado), 1);
        reset_n = 1'b0;
        #1;
        check_outputs_zero("abort");
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        repeat (12) @(negedge clock);
        check("abort.idle_after", int'(ocupado), 0);

        start(4'b0010, 8'd1, 8'd2, 8'd3, 0, 0, 0, 0, 0, 0, "add_1_2_after_abort");
        finish_op(2);

        check("scoreboard_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
